// File: rtl/axi4_lite_Defs.sv
// -----------------------------------------------------------------------------
// axi4_lite_Defs
// Shared AXI4-Lite definitions: response codes, the slave-side phase enum,
// the command-master FSM state enum, the command record and small helpers.
// -----------------------------------------------------------------------------
package axi4_lite_Defs;

  // Default bus widths; the command master uses these as parameter defaults.
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Slave-side transfer phases.
  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } axi_phase_t;

  // Command-master FSM states; the M_ prefix keeps them apart from axi_phase_t.
  typedef enum logic [2:0] {
    M_IDLE,
    M_WR,
    M_WR_RESP,
    M_RD_ADDR,
    M_RD_DATA,
    M_RESP
  } mstate_t;

  // One queued command at the default bus widths.
  typedef struct packed {
    logic                      write;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [AXI_DATA_WIDTH-1:0] wdata;
    logic [AXI_STRB_WIDTH-1:0] wstrb;
  } cmd_t;

  // SLVERR and DECERR both have bit 1 set; OKAY and EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

  // 16-bit counter step that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/axi4_lite_cmd_fifo.sv
// -----------------------------------------------------------------------------
// axi4_lite_cmd_fifo
// Synchronous FIFO, registered count, no bypass path (rdata always shows the
// stored head entry).
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write one entry when not full
//   pop/rdata  : drop the head entry when not empty; rdata is the head
//   full/empty : derived from the registered count
//   count      : number of stored entries (0..DEPTH)
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module axi4_lite_cmd_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its inputs from before the edge, regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; emptiness is tracked by count, and leaving the
  // array unreset lets it map onto plain flops or RAM without reset muxes.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/axi4_lite_cmd_master.sv
// -----------------------------------------------------------------------------
// axi4_lite_cmd_master
// AXI4-Lite master driven by a local command queue. Commands are accepted on
// cmd_* into a FIFO, executed strictly one at a time in order, and each result
// is returned on rsp_*.
//   ACLK, ARESETN        : clock, asynchronous active-low reset (shared with
//                          the slave)
//   cmd_valid/cmd_ready  : command handshake; cmd_ready = FIFO not full
//   cmd_write/addr/wdata/wstrb : command fields (wstrb passed unchanged, 0 ok)
//   rsp_valid/rsp_ready  : result handshake, held until consumed
//   rsp_write/rdata/resp : result fields (rdata is 0 for writes)
//   busy                 : FSM active or commands queued
//   AW*/W*/B*/AR*/R*     : AXI4-Lite master channels
// Optional: define AXI4_LITE_MASTER_STATS_EN to add saturating 16-bit
// stat_wr_cnt / stat_rd_cnt / stat_err_cnt outputs.
// All outputs are registered except cmd_ready.
// -----------------------------------------------------------------------------
module axi4_lite_cmd_master
  import axi4_lite_Defs::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int CMD_DEPTH  = 4
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  // command port
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  // response port
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      busy,
`ifdef AXI4_LITE_MASTER_STATS_EN
  output logic [15:0]               stat_wr_cnt,
  output logic [15:0]               stat_rd_cnt,
  output logic [15:0]               stat_err_cnt,
`endif
  // write address / data / response
  output logic [ADDR_WIDTH-1:0]     AWADDR,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [DATA_WIDTH-1:0]     WDATA,
  output logic [DATA_WIDTH/8-1:0]   WSTRB,
  output logic                      WVALID,
  input  logic                      WREADY,
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  output logic                      BREADY,
  // read address / data
  output logic [ADDR_WIDTH-1:0]     ARADDR,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  input  logic [DATA_WIDTH-1:0]     RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RVALID,
  output logic                      RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CMD_W  = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_W;
  localparam int CNT_W  = $clog2(CMD_DEPTH) + 1;

  mstate_t state;

  logic [CMD_W-1:0]      fifo_wdata;
  logic [CMD_W-1:0]      fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      count_next;

  logic                  head_write;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic [STRB_W-1:0]     head_wstrb;

  logic                  push_fire;
  logic                  pop_fire;
  logic                  to_idle;
  logic                  b_fire;
  logic                  r_fire;

  // Command record packed in the same field order as cmd_t.
  assign fifo_wdata = {cmd_write, cmd_addr, cmd_wdata, cmd_wstrb};
  assign {head_write, head_addr, head_wdata, head_wstrb} = fifo_rdata;

  assign cmd_ready = !fifo_full;
  assign push_fire = cmd_valid && !fifo_full;
  // Popping only from M_IDLE against a registered empty flag means a freshly
  // pushed command is issued no earlier than the edge after it was accepted.
  assign pop_fire  = (state == M_IDLE) && !fifo_empty;
  assign b_fire    = (state == M_WR_RESP) && BVALID && BREADY;
  assign r_fire    = (state == M_RD_DATA) && RVALID && RREADY;

  // FSM lands in M_IDLE on this edge: idle with nothing to pop, or result taken.
  assign to_idle = ((state == M_IDLE) && fifo_empty) ||
                   ((state == M_RESP) && rsp_ready);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_next = fifo_count;
    if (push_fire && !pop_fire)      count_next = fifo_count + 1'b1;
    else if (pop_fire && !push_fire) count_next = fifo_count - 1'b1;
  end

  axi4_lite_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .push  (push_fire),
    .wdata (fifo_wdata),
    .pop   (pop_fire),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= M_IDLE;
      AWADDR    <= '0;
      AWVALID   <= 1'b0;
      WDATA     <= '0;
      WSTRB     <= '0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARADDR    <= '0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= RESP_OKAY;
      busy      <= 1'b0;
    end else begin
      // busy mirrors the post-edge FSM state and FIFO occupancy.
      busy <= !(to_idle && (count_next == '0));

      case (state)
        M_IDLE: begin
          if (pop_fire) begin
            if (head_write) begin
              AWADDR  <= head_addr;
              WDATA   <= head_wdata;
              WSTRB   <= head_wstrb;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              state   <= M_WR;
            end else begin
              ARADDR  <= head_addr;
              ARVALID <= 1'b1;
              state   <= M_RD_ADDR;
            end
          end
        end

        M_WR: begin
          // AW and W retire independently; a channel already retired counts
          // as done, so either order (or the same edge) reaches M_WR_RESP.
          if (AWVALID && AWREADY) AWVALID <= 1'b0;
          if (WVALID && WREADY)   WVALID  <= 1'b0;
          if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) begin
            BREADY <= 1'b1;
            state  <= M_WR_RESP;
          end
        end

        M_WR_RESP: begin
          if (b_fire) begin
            BREADY    <= 1'b0;
            rsp_resp  <= BRESP;
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            state     <= M_RESP;
          end
        end

        M_RD_ADDR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= M_RD_DATA;
          end
        end

        M_RD_DATA: begin
          // Data is kept even on an error response.
          if (r_fire) begin
            RREADY    <= 1'b0;
            rsp_rdata <= RDATA;
            rsp_resp  <= RRESP;
            rsp_write <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= M_RESP;
          end
        end

        M_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= M_IDLE;
          end
        end

        default: state <= M_IDLE;
      endcase
    end
  end

`ifdef AXI4_LITE_MASTER_STATS_EN
  logic err_fire;

  assign err_fire = (b_fire && resp_is_err(BRESP)) ||
                    (r_fire && resp_is_err(RRESP));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      stat_wr_cnt  <= '0;
      stat_rd_cnt  <= '0;
      stat_err_cnt <= '0;
    end else begin
      if (b_fire)   stat_wr_cnt  <= sat_inc16(stat_wr_cnt);
      if (r_fire)   stat_rd_cnt  <= sat_inc16(stat_rd_cnt);
      if (err_fire) stat_err_cnt <= sat_inc16(stat_err_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_cmd_master
// Directed bench for axi4_lite_cmd_master (32-bit address/data, depth 4).
// The bench plays the AXI slave; inputs change and outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_axi4_lite_cmd_master;

  logic        ACLK;
  logic        ARESETN;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;
`ifdef AXI4_LITE_MASTER_STATS_EN
  logic [15:0] stat_wr_cnt;
  logic [15:0] stat_rd_cnt;
  logic [15:0] stat_err_cnt;
`endif
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int n_vec  = 0;
  int n_miss = 0;
  logic rsp0_done;

  axi4_lite_cmd_master #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .CMD_DEPTH  (4)
  ) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .busy      (busy),
`ifdef AXI4_LITE_MASTER_STATS_EN
    .stat_wr_cnt  (stat_wr_cnt),
    .stat_rd_cnt  (stat_rd_cnt),
    .stat_err_cnt (stat_err_cnt),
`endif
    .AWADDR    (AWADDR),
    .AWVALID   (AWVALID),
    .AWREADY   (AWREADY),
    .WDATA     (WDATA),
    .WSTRB     (WSTRB),
    .WVALID    (WVALID),
    .WREADY    (WREADY),
    .BRESP     (BRESP),
    .BVALID    (BVALID),
    .BREADY    (BREADY),
    .ARADDR    (ARADDR),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .RVALID    (RVALID),
    .RREADY    (RREADY)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge ACLK);
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0:       return AWVALID && WVALID;
      1:       return ARVALID;
      2:       return rsp_valid;
      default: return 1'b0;
    endcase
  endfunction

  // Bounded wait for a DUT condition; an expired bound is a failed compare.
  task automatic wait_hi(input int sel, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (probe(sel)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_wait"}, ok, 1);
  endtask

  // Offer one command; returns on the falling edge after it was accepted.
  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input string tag);
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) break;
      tick();
    end
    check({tag, "_accept"}, cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic serve_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] resp,
                             input string tag);
    wait_hi(0, {tag, "_aw"});
    check({tag, "_awaddr"}, AWADDR, a);
    check({tag, "_wdata"},  WDATA,  d);
    check({tag, "_wstrb"},  WSTRB,  s);
    AWREADY = 1'b1;
    WREADY  = 1'b1;
    tick();
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    check({tag, "_aw_w_drop"}, {AWVALID, WVALID}, 2'b00);
    check({tag, "_bready"}, BREADY, 1);
    BVALID = 1'b1;
    BRESP  = resp;
    tick();
    BVALID = 1'b0;
    BRESP  = 2'b00;
    check({tag, "_bready_drop"}, BREADY, 0);
  endtask

  task automatic serve_read(input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] resp, input string tag);
    wait_hi(1, {tag, "_ar"});
    check({tag, "_araddr"}, ARADDR, a);
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    check({tag, "_arvalid_drop"}, ARVALID, 0);
    check({tag, "_rready"}, RREADY, 1);
    RVALID = 1'b1;
    RDATA  = d;
    RRESP  = resp;
    tick();
    RVALID = 1'b0;
    RDATA  = '0;
    RRESP  = 2'b00;
    check({tag, "_rready_drop"}, RREADY, 0);
  endtask

  task automatic take_rsp(input logic w, input logic [31:0] d, input logic [1:0] resp,
                          input string tag);
    wait_hi(2, {tag, "_rsp"});
    check({tag, "_rsp_write"}, rsp_write, w);
    check({tag, "_rsp_rdata"}, rsp_rdata, d);
    check({tag, "_rsp_resp"},  rsp_resp,  resp);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, rsp_valid, 0);
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    rsp_ready = 1'b0;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    BRESP     = 2'b00;
    ARREADY   = 1'b0;
    RVALID    = 1'b0;
    RDATA     = '0;
    RRESP     = 2'b00;
    rsp0_done = 1'b0;
    ARESETN   = 1'b0;
    repeat (3) tick();
    ARESETN = 1'b1;
    tick();

    // ---- reset state ----
    check("rst_handshakes", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 5'b0);
    check("rst_addr_data", {AWADDR, ARADDR, WDATA, 28'b0, WSTRB}, 128'b0);
    check("rst_rsp", {rsp_valid, rsp_write, rsp_rdata, rsp_resp}, 36'b0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
`ifdef AXI4_LITE_MASTER_STATS_EN
    check("rst_stats", {stat_wr_cnt, stat_rd_cnt, stat_err_cnt}, 48'b0);
`endif

    // ---- T1: write, AWREADY and WREADY together ----
    push(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, "t1");
    check("t1_no_bypass", AWVALID, 0);
    check("t1_busy", busy, 1);
    tick();
    check("t1_valids_up", {AWVALID, WVALID}, 2'b11);
    serve_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, "t1");
    take_rsp(1'b1, 32'h0, 2'b00, "t1");
    check("t1_idle", busy, 0);

    // ---- T2: WREADY three cycles ahead of AWREADY ----
    push(1'b1, 32'h0000_0044, 32'hCAFE_F00D, 4'h5, "t2");
    wait_hi(0, "t2_aw");
    WREADY = 1'b1;
    tick();
    WREADY = 1'b0;
    check("t2_wvalid_drop", WVALID, 0);
    check("t2_awvalid_hold", AWVALID, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t2_awvalid_hold", AWVALID, 1);
      check("t2_awaddr_stable", AWADDR, 32'h0000_0044);
      check("t2_wdata_stable", WDATA, 32'hCAFE_F00D);
      check("t2_no_bready", BREADY, 0);
    end
    AWREADY = 1'b1;
    tick();
    AWREADY = 1'b0;
    check("t2_awvalid_drop", AWVALID, 0);
    check("t2_bready", BREADY, 1);
    BVALID = 1'b1;
    BRESP  = 2'b00;
    tick();
    BVALID = 1'b0;
    take_rsp(1'b1, 32'h0, 2'b00, "t2");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_single_rsp", rsp_valid, 0);
    end
    check("t2_idle", busy, 0);

    // ---- T3: read with SLVERR, data still returned ----
    push(1'b0, 32'h0000_0020, 32'h0, 4'h0, "t3");
    serve_read(32'h0000_0020, 32'h1234_5678, 2'b10, "t3");
    take_rsp(1'b0, 32'h1234_5678, 2'b10, "t3");
`ifdef AXI4_LITE_MASTER_STATS_EN
    check("t3_stat_err", stat_err_cnt, 16'd1);
    check("t3_stat_rd", stat_rd_cnt, 16'd1);
    check("t3_stat_wr", stat_wr_cnt, 16'd2);
`endif

    // ---- T4: FIFO fills behind a stalled read, order preserved ----
    push(1'b0, 32'h0000_00F0, 32'h0, 4'h0, "t4_c0");
    wait_hi(1, "t4_c0_ar");
    push(1'b1, 32'h0000_0100, 32'h1111_1111, 4'hF, "t4_p1");
    check("t4_ready_after_1", cmd_ready, 1);
    push(1'b0, 32'h0000_0104, 32'h0, 4'h0, "t4_p2");
    check("t4_ready_after_2", cmd_ready, 1);
    push(1'b1, 32'h0000_0108, 32'h3333_3333, 4'h0, "t4_p3");
    check("t4_ready_after_3", cmd_ready, 1);
    push(1'b0, 32'h0000_010C, 32'h0, 4'h0, "t4_p4");
    check("t4_full_after_4", cmd_ready, 0);
    check("t4_busy", busy, 1);
    fork
      begin
        push(1'b1, 32'h0000_0110, 32'h5555_5555, 4'hC, "t4_p5");
        check("t4_p5_after_pop", rsp0_done, 1);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          tick();
          check("t4_stall_full", cmd_ready, 0);
        end
        serve_read(32'h0000_00F0, 32'h0000_C0DE, 2'b00, "t4_c0");
        take_rsp(1'b0, 32'h0000_C0DE, 2'b00, "t4_c0");
        rsp0_done = 1'b1;
      end
    join
    serve_write(32'h0000_0100, 32'h1111_1111, 4'hF, 2'b00, "t4_p1");
    take_rsp(1'b1, 32'h0, 2'b00, "t4_p1");
    serve_read(32'h0000_0104, 32'hA5A5_A5A5, 2'b00, "t4_p2");
    take_rsp(1'b0, 32'hA5A5_A5A5, 2'b00, "t4_p2");
    serve_write(32'h0000_0108, 32'h3333_3333, 4'h0, 2'b00, "t4_p3");
    take_rsp(1'b1, 32'h0, 2'b00, "t4_p3");
    serve_read(32'h0000_010C, 32'h0BAD_F00D, 2'b11, "t4_p4");
    take_rsp(1'b0, 32'h0BAD_F00D, 2'b11, "t4_p4");
    serve_write(32'h0000_0110, 32'h5555_5555, 4'hC, 2'b10, "t4_p5");
    take_rsp(1'b1, 32'h0, 2'b10, "t4_p5");

    // ---- T5: result held 10 cycles while the FIFO fills ----
    push(1'b0, 32'h0000_0200, 32'h0, 4'h0, "t5");
    serve_read(32'h0000_0200, 32'hFEED_FACE, 2'b00, "t5");
    wait_hi(2, "t5_rsp_up");
    for (int i = 0; i < 10; i++) begin
      check("t5_rsp_valid_hold", rsp_valid, 1);
      check("t5_rsp_rdata_hold", rsp_rdata, 32'hFEED_FACE);
      check("t5_no_new_axvalid", {AWVALID, ARVALID}, 2'b00);
      check("t5_cmd_ready", cmd_ready, (i < 4) ? 1'b1 : 1'b0);
      cmd_valid = (i < 4);
      cmd_write = 1'b1;
      cmd_addr  = 32'h0000_0300 + 32'(4 * i);
      cmd_wdata = 32'(i + 1);
      cmd_wstrb = 4'hF;
      tick();
    end
    cmd_valid = 1'b0;
    take_rsp(1'b0, 32'hFEED_FACE, 2'b00, "t5_hold");
    for (int i = 0; i < 4; i++) begin
      serve_write(32'h0000_0300 + 32'(4 * i), 32'(i + 1), 4'hF, 2'b00, "t5_drain");
      take_rsp(1'b1, 32'h0, 2'b00, "t5_drain");
    end
    check("t5_idle", busy, 0);
`ifdef AXI4_LITE_MASTER_STATS_EN
    check("t5_stat_wr", stat_wr_cnt, 16'd9);
    check("t5_stat_rd", stat_rd_cnt, 16'd5);
    check("t5_stat_err", stat_err_cnt, 16'd3);
`endif

    // ---- T6: reset while AWVALID is high ----
    push(1'b1, 32'h0000_0500, 32'hAAAA_0001, 4'hF, "t6_a");
    push(1'b1, 32'h0000_0504, 32'hAAAA_0002, 4'hF, "t6_b");
    wait_hi(0, "t6_aw");
    ARESETN = 1'b0;
    #1;
    check("t6_async_handshakes", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 5'b0);
    check("t6_async_busy", busy, 0);
    check("t6_async_cmd_ready", cmd_ready, 1);
    tick();
    ARESETN = 1'b1;
    tick();
    check("t6_cmd_ready", cmd_ready, 1);
    check("t6_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_queue_dropped", {AWVALID, WVALID, ARVALID}, 3'b000);
    end
`ifdef AXI4_LITE_MASTER_STATS_EN
    check("t6_stats_cleared", {stat_wr_cnt, stat_rd_cnt, stat_err_cnt}, 48'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
